// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86 icode and register-index constants
package y86_pkg;

    typedef enum logic [3:0] {
        I_HALT  = 4'h0,
        I_NOP   = 4'h1,
        I_CMOV  = 4'h2,
        I_IRMOV = 4'h3,
        I_RMMOV = 4'h4,
        I_MRMOV = 4'h5,
        I_OP    = 4'h6,
        I_JXX   = 4'h7,
        I_CALL  = 4'h8,
        I_RET   = 4'h9,
        I_PUSH  = 4'hA,
        I_POP   = 4'hB
    } icode_e;

    localparam logic [3:0] RNONE       = 4'hF;
    localparam int         RSP_DEFAULT = 4;

endpackage

// File: rtl/y86_wb_dst_decode.sv
// rtl/y86_wb_dst_decode.sv - combinational write-back destination decode
module y86_wb_dst_decode
    import y86_pkg::*;
#(
    parameter int RSP_ID = RSP_DEFAULT
) (
    input  logic [3:0] icode,
    input  logic       Cnd,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    output logic [3:0] dst_e,
    output logic [3:0] dst_m
);

    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        case (icode)
            I_CMOV:                       dst_e = Cnd ? rB : RNONE;
            I_IRMOV, I_OP:                dst_e = rB;
            I_CALL, I_RET, I_PUSH:        dst_e = 4'(RSP_ID);
            I_POP: begin
                dst_e = 4'(RSP_ID);
                dst_m = rA;
            end
            I_MRMOV:                      dst_m = rA;
            default: begin
                dst_e = RNONE;
                dst_m = RNONE;
            end
        endcase
    end

endmodule

// File: rtl/y86_regfile_wb.sv
// rtl/y86_regfile_wb.sv - Y86 write-back stage, register file, halt and retire tracking
module y86_regfile_wb
    import y86_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int NREG   = 15,
    parameter int RSP_ID = RSP_DEFAULT,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_valid,
    input  logic                 wb_stall,
    input  logic [3:0]           icode,
    input  logic                 Cnd,
    input  logic [3:0]           rA,
    input  logic [3:0]           rB,
    input  logic [XLEN-1:0]      valE,
    input  logic [XLEN-1:0]      valM,
    input  logic [3:0]           srcA,
    input  logic [3:0]           srcB,
    output logic [XLEN-1:0]      rdataA,
    output logic [XLEN-1:0]      rdataB,
    output logic                 halted,
    output logic [CNT_W-1:0]     retired,
    output logic [NREG*XLEN-1:0] regs_flat
);

    logic [3:0]      dst_e;
    logic [3:0]      dst_m;
    logic            we;
    logic            halt_now;
    logic [XLEN-1:0] regs [NREG];

    y86_wb_dst_decode #(
        .RSP_ID (RSP_ID)
    ) u_dst_decode (
        .icode (icode),
        .Cnd   (Cnd),
        .rA    (rA),
        .rB    (rB),
        .dst_e (dst_e),
        .dst_m (dst_m)
    );

    assign we       = wb_valid & ~wb_stall & ~halted;
    assign halt_now = wb_valid & ~wb_stall & (icode == I_HALT);

    // Indices RNONE and >= NREG never match a loop index, so they write nothing.
    // Checking M last-wins gives popq %rsp its memory value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < NREG; i++) begin
                if (dst_m == 4'(i)) begin
                    regs[i] <= valM;
                end else if (dst_e == 4'(i)) begin
                    regs[i] <= valE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted  <= 1'b0;
            retired <= '0;
        end else begin
            if (we) begin
                retired <= retired + CNT_W'(1);
            end
            if (halt_now) begin
                halted <= 1'b1;
            end
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [3:0] src);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < NREG; i++) begin
            if (src == 4'(i)) begin
                r = regs[i];
                if (BYPASS != 0 && we) begin
                    if (dst_m == src) begin
                        r = valM;
                    end else if (dst_e == src) begin
                        r = valE;
                    end
                end
            end
        end
        return r;
    endfunction

    // Reads are forced to zero during reset even if bypass inputs are live.
    assign rdataA = rst_n ? read_port(srcA) : '0;
    assign rdataB = rst_n ? read_port(srcB) : '0;

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_flat[g*XLEN +: XLEN] = regs[g];
    end

endmodule

// File: tb/tb_y86_regfile_wb.sv
// tb/tb_y86_regfile_wb.sv - self-checking bench for y86_regfile_wb
module tb_y86_regfile_wb;

    localparam int XLEN  = 64;
    localparam int NREG  = 15;
    localparam int CNT_W = 32;

    logic                 clk;
    logic                 rst_n;
    logic                 wb_valid;
    logic                 wb_stall;
    logic [3:0]           icode;
    logic                 Cnd;
    logic [3:0]           rA;
    logic [3:0]           rB;
    logic [XLEN-1:0]      valE;
    logic [XLEN-1:0]      valM;
    logic [3:0]           srcA;
    logic [3:0]           srcB;
    logic [XLEN-1:0]      rdataA;
    logic [XLEN-1:0]      rdataB;
    logic                 halted;
    logic [CNT_W-1:0]     retired;
    logic [NREG*XLEN-1:0] regs_flat;

    int tests = 0;
    int fails = 0;

    logic [63:0] m_regs [NREG];
    logic        m_halted;
    logic [31:0] m_retired;

    y86_regfile_wb #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .RSP_ID (4),
        .BYPASS (1),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_stall  (wb_stall),
        .icode     (icode),
        .Cnd       (Cnd),
        .rA        (rA),
        .rB        (rB),
        .valE      (valE),
        .valM      (valM),
        .srcA      (srcA),
        .srcB      (srcB),
        .rdataA    (rdataA),
        .rdataB    (rdataB),
        .halted    (halted),
        .retired   (retired),
        .regs_flat (regs_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void dsts(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                                 input logic [3:0] rb, output logic [3:0] de, output logic [3:0] dm);
        de = 4'hF;
        dm = 4'hF;
        if (ic == 4'h2 && c) de = rb;
        if (ic == 4'h3 || ic == 4'h6) de = rb;
        if (ic >= 4'h8 && ic <= 4'hB) de = 4'd4;
        if (ic == 4'h5 || ic == 4'hB) dm = ra;
    endfunction

    function automatic bit model_we();
        return (rst_n === 1'b1) && wb_valid && !wb_stall && !m_halted;
    endfunction

    function automatic logic [63:0] exp_read(input logic [3:0] s);
        logic [3:0] de, dm;
        dsts(icode, Cnd, rA, rB, de, dm);
        if (rst_n !== 1'b1 || s >= NREG) return 64'h0;
        if (model_we() && s == dm) return valM;
        if (model_we() && s == de) return valE;
        return m_regs[s];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = 64'h0;
        m_halted  = 1'b0;
        m_retired = 32'h0;
    endtask

    task automatic model_edge();
        logic [3:0] de, dm;
        dsts(icode, Cnd, rA, rB, de, dm);
        if (model_we()) begin
            if (de < NREG) m_regs[de] = valE;
            if (dm < NREG) m_regs[dm] = valM;
            m_retired = m_retired + 32'd1;
        end
        if (wb_valid && !wb_stall && icode == 4'h0) m_halted = 1'b1;
    endtask

    task automatic chk_state(input string tag);
        for (int i = 0; i < NREG; i++)
            chk($sformatf("%s.R%0d", tag, i), regs_flat[i*XLEN +: XLEN], m_regs[i]);
        chk({tag, ".halted"}, 64'(halted), 64'(m_halted));
        chk({tag, ".retired"}, 64'(retired), 64'(m_retired));
    endtask

    task automatic drive(input logic v, input logic st, input logic [3:0] ic, input logic c,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] ve,
                         input logic [63:0] vm, input logic [3:0] sa, input logic [3:0] sb);
        wb_valid = v; wb_stall = st; icode = ic; Cnd = c;
        rA = ra; rB = rb; valE = ve; valM = vm; srcA = sa; srcB = sb;
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        chk({tag, ".rdA"}, rdataA, exp_read(srcA));
        chk({tag, ".rdB"}, rdataB, exp_read(srcB));
        @(posedge clk);
        model_edge();
        #1;
        chk_state(tag);
    endtask

    logic [31:0] r0;
    logic [63:0] r5;

    initial begin
        model_reset();
        rst_n = 1'b0;
        drive(1, 0, 4'h3, 0, 4'hF, 4'h0, 64'h55, 64'h66, 4'h0, 4'h0);
        #1;
        chk("reset.rdA_bypass_gated", rdataA, 64'h0);
        chk_state("reset");
        @(posedge clk);
        #1;
        chk_state("reset_edge");
        rst_n = 1'b1;

        drive(1, 0, 4'h3, 0, 4'hF, 4'h3, 64'h1234, 64'h0, 4'h3, 4'hF);
        cycle("irmov");
        chk("irmov.R3", regs_flat[3*XLEN +: XLEN], 64'h1234);

        drive(1, 0, 4'h6, 0, 4'h1, 4'h3, 64'h10, 64'h0, 4'h3, 4'h1);
        cycle("opq");
        chk("opq.R3", regs_flat[3*XLEN +: XLEN], 64'h10);
        chk("opq.retired", 64'(retired), 64'd2);

        drive(1, 0, 4'h2, 0, 4'h1, 4'h2, 64'h99, 64'h0, 4'h2, 4'hF);
        cycle("cmov0");
        chk("cmov0.R2", regs_flat[2*XLEN +: XLEN], 64'h0);
        chk("cmov0.retired", 64'(retired), 64'd3);

        drive(1, 0, 4'h2, 1, 4'h1, 4'h2, 64'h7, 64'h0, 4'h2, 4'hF);
        cycle("cmov1");
        chk("cmov1.R2", regs_flat[2*XLEN +: XLEN], 64'h7);

        drive(1, 0, 4'hB, 0, 4'h4, 4'hF, 64'h108, 64'hAA, 4'hF, 4'h4);
        #1;
        chk("pop_rsp.bypassB", rdataB, 64'hAA);
        cycle("pop_rsp");
        chk("pop_rsp.R4", regs_flat[4*XLEN +: XLEN], 64'hAA);

        drive(1, 0, 4'hB, 0, 4'h3, 4'hF, 64'h110, 64'h55, 4'h4, 4'h3);
        cycle("pop_rbx");
        chk("pop_rbx.R4", regs_flat[4*XLEN +: XLEN], 64'h110);
        chk("pop_rbx.R3", regs_flat[3*XLEN +: XLEN], 64'h55);

        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                  4'($urandom_range(1, 11)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  {$urandom(), $urandom()}, {$urandom(), $urandom()},
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            cycle($sformatf("rnd%0d", n));
        end

        r0 = m_retired;
        drive(1, 1, 4'h3, 0, 4'hF, 4'h6, 64'hBEEF, 64'h0, 4'h6, 4'hF);
        for (int k = 0; k < 3; k++) cycle("stall");
        wb_stall = 1'b0;
        cycle("unstall");
        chk("stall.R6", regs_flat[6*XLEN +: XLEN], 64'hBEEF);
        chk("stall.retired", 64'(retired), 64'(r0 + 32'd1));

        drive(1, 0, 4'h0, 0, 4'hF, 4'hF, 64'h0, 64'h0, 4'hF, 4'hF);
        cycle("halt");
        chk("halt.halted", 64'(halted), 64'd1);
        chk("halt.retired", 64'(retired), 64'(r0 + 32'd2));

        r5 = m_regs[5];
        drive(1, 0, 4'h3, 0, 4'hF, 4'h5, 64'hDEAD, 64'h0, 4'h5, 4'hF);
        cycle("post_halt");
        chk("post_halt.R5", regs_flat[5*XLEN +: XLEN], r5);
        chk("post_halt.retired", 64'(retired), 64'(r0 + 32'd2));

        drive(1, 0, 4'h3, 0, 4'hF, 4'h1, 64'h77, 64'h0, 4'h1, 4'hF);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midreset.rdA", rdataA, 64'h0);
        chk_state("midreset");
        @(posedge clk);
        #1;
        chk_state("midreset_edge");
        rst_n = 1'b1;
        cycle("after_reset");
        chk("after_reset.R1", regs_flat[1*XLEN +: XLEN], 64'h77);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
